// File: rtl/keycmd_pkg.sv
// Shared types and keycodes for keycode_cmd_decoder.
package keycmd_pkg;

  localparam int unsigned KEY_W = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DIR_W = 2;

  typedef enum logic [DIR_W-1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    READY    = 1'b0,
    COOLDOWN = 1'b1
  } fire_state_t;

  localparam logic [KEY_W-1:0] P1_KEY_UP    = 8'h1A;
  localparam logic [KEY_W-1:0] P1_KEY_DOWN  = 8'h16;
  localparam logic [KEY_W-1:0] P1_KEY_LEFT  = 8'h04;
  localparam logic [KEY_W-1:0] P1_KEY_RIGHT = 8'h07;
  localparam logic [KEY_W-1:0] P1_KEY_FIRE  = 8'h2C;
  localparam logic [KEY_W-1:0] P2_KEY_UP    = 8'h52;
  localparam logic [KEY_W-1:0] P2_KEY_DOWN  = 8'h51;
  localparam logic [KEY_W-1:0] P2_KEY_LEFT  = 8'h50;
  localparam logic [KEY_W-1:0] P2_KEY_RIGHT = 8'h4F;
  localparam logic [KEY_W-1:0] P2_KEY_FIRE  = 8'h28;

endpackage

// File: rtl/keycmd_player.sv
// One player's key decode, facing register, move/fire pulses and fire cooldown FSM.
// KEYCMD_AUTOFIRE_EN: a held fire key re-fires each time the cooldown expires.
module keycmd_player
  import keycmd_pkg::*;
#(
  parameter int unsigned       FIRE_COOLDOWN = 30,
  parameter logic [DIR_W-1:0]  INIT_DIR      = 2'd0,
  parameter logic [KEY_W-1:0]  KEY_UP        = P1_KEY_UP,
  parameter logic [KEY_W-1:0]  KEY_DOWN      = P1_KEY_DOWN,
  parameter logic [KEY_W-1:0]  KEY_LEFT      = P1_KEY_LEFT,
  parameter logic [KEY_W-1:0]  KEY_RIGHT     = P1_KEY_RIGHT,
  parameter logic [KEY_W-1:0]  KEY_FIRE      = P1_KEY_FIRE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_q,
  input  logic [KEY_W-1:0] key_prev,
  input  logic             edge_en,
  input  logic             frame_tick,
  input  logic             freeze,
  output logic             move,
  output logic [DIR_W-1:0] dir,
  output logic             fire,
  output logic             ready
);

  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(FIRE_COOLDOWN);

  fire_state_t      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [DIR_W-1:0] dir_d;
  logic             move_d, fire_d;
  logic             dir_hit, fire_edge, fire_held;
  dir_t             dir_val;

  // Next-state, counter and command generation
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    dir_d   = dir;
    move_d  = 1'b0;
    fire_d  = 1'b0;
    dir_hit = 1'b1;
    dir_val = UP;

    case (key_q)
      KEY_UP:    dir_val = UP;
      KEY_DOWN:  dir_val = DOWN;
      KEY_LEFT:  dir_val = LEFT;
      KEY_RIGHT: dir_val = RIGHT;
      default:   dir_hit = 1'b0;
    endcase

    fire_held = (key_q == KEY_FIRE);
    fire_edge = edge_en && fire_held && (key_prev != KEY_FIRE);

    if (frame_tick && dir_hit && !freeze) begin
      dir_d  = dir_val;
      move_d = 1'b1;
    end

    case (state)
      READY: begin
        // Load wins over a coincident frame_tick
        if (fire_edge && !freeze) begin
          fire_d  = 1'b1;
          state_d = COOLDOWN;
          cnt_d   = COOL_LOAD;
        end
      end
      COOLDOWN: begin
        // Keeps counting under freeze; fire edges here are dropped
        if (frame_tick) begin
          if (cnt <= CNT_W'(1)) begin
`ifdef KEYCMD_AUTOFIRE_EN
            if (fire_held && !freeze) begin
              fire_d = 1'b1;
              cnt_d  = COOL_LOAD;
            end else begin
              state_d = READY;
              cnt_d   = '0;
            end
`else
            state_d = READY;
            cnt_d   = '0;
`endif
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = READY;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= READY;
      cnt   <= '0;
      dir   <= INIT_DIR;
      move  <= 1'b0;
      fire  <= 1'b0;
      ready <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      dir   <= dir_d;
      move  <= move_d;
      fire  <= fire_d;
      ready <= (state_d == READY);
    end
  end

endmodule

// File: rtl/keycode_cmd_decoder.sv
// Keycode to two-player move/fire command decoder; shared keycode pipeline only.
// KEYCMD_AUTOFIRE_EN (see keycmd_player) enables hold-to-autofire.
module keycode_cmd_decoder
  import keycmd_pkg::*;
#(
  parameter int unsigned      FIRE_COOLDOWN = 30,
  parameter logic [DIR_W-1:0] P1_INIT_DIR   = 2'd0,
  parameter logic [DIR_W-1:0] P2_INIT_DIR   = 2'd1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [KEY_W-1:0] keycode,
  input  logic             frame_tick,
  input  logic             freeze,
  output logic             p1_move,
  output logic             p2_move,
  output logic [DIR_W-1:0] p1_dir,
  output logic [DIR_W-1:0] p2_dir,
  output logic             p1_fire,
  output logic             p2_fire,
  output logic             p1_ready,
  output logic             p2_ready
);

  logic [KEY_W-1:0] key_q, key_prev;
  logic [1:0]       key_vld;

  // key_vld[1] marks key_prev as a real sample, so a key held through reset is no edge
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_q    <= '0;
      key_prev <= '0;
      key_vld  <= '0;
    end else begin
      key_q    <= keycode;
      key_prev <= key_q;
      key_vld  <= {key_vld[0], 1'b1};
    end
  end

  keycmd_player #(
    .FIRE_COOLDOWN(FIRE_COOLDOWN), .INIT_DIR(P1_INIT_DIR),
    .KEY_UP(P1_KEY_UP), .KEY_DOWN(P1_KEY_DOWN), .KEY_LEFT(P1_KEY_LEFT),
    .KEY_RIGHT(P1_KEY_RIGHT), .KEY_FIRE(P1_KEY_FIRE)
  ) u_p1 (
    .clk(Clk), .rst_n(Reset_n), .key_q(key_q), .key_prev(key_prev),
    .edge_en(key_vld[1]), .frame_tick(frame_tick), .freeze(freeze),
    .move(p1_move), .dir(p1_dir), .fire(p1_fire), .ready(p1_ready)
  );

  keycmd_player #(
    .FIRE_COOLDOWN(FIRE_COOLDOWN), .INIT_DIR(P2_INIT_DIR),
    .KEY_UP(P2_KEY_UP), .KEY_DOWN(P2_KEY_DOWN), .KEY_LEFT(P2_KEY_LEFT),
    .KEY_RIGHT(P2_KEY_RIGHT), .KEY_FIRE(P2_KEY_FIRE)
  ) u_p2 (
    .clk(Clk), .rst_n(Reset_n), .key_q(key_q), .key_prev(key_prev),
    .edge_en(key_vld[1]), .frame_tick(frame_tick), .freeze(freeze),
    .move(p2_move), .dir(p2_dir), .fire(p2_fire), .ready(p2_ready)
  );

endmodule

// File: doc/keycode_cmd_decoder.md
KEYCODE_CMD_DECODER -- requirements
Module: keycode_cmd_decoder

Interface
REQ-001 SHALL have parameter FIRE_COOLDOWN, default 30, the number of frame_tick pulses after a fire during which further fires are suppressed (range 1..255).
REQ-002 SHALL have parameter P1_INIT_DIR, default 0, player-1 direction at reset.
REQ-003 SHALL have parameter P2_INIT_DIR, default 1, player-2 direction at reset.
REQ-004 Clk  input  1  system clock (50 MHz); all state changes on its rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 keycode  input  8  USB HID keycode from the SoC keycode PIO, same clock domain; 0x00 means no key.
REQ-007 frame_tick  input  1  one-Clk-wide pulse, once per video frame.
REQ-008 freeze  input  1  game-over hold (win1|win2); level-sensitive.
REQ-009 p1_move, p2_move  output  1  one-cycle move command.
REQ-010 p1_dir, p2_dir  output  2  current facing: 0 up, 1 down, 2 left, 3 right.
REQ-011 p1_fire, p2_fire  output  1  one-cycle fire command.
REQ-012 p1_ready, p2_ready  output  1  high when the fire FSM is in READY.

Function
REQ-013 SHALL register keycode into key_q every cycle and key_q into key_prev every cycle.
REQ-014 Player-1 keys SHALL be W 0x1A up, S 0x16 down, A 0x04 left, D 0x07 right, Space 0x2C fire.
REQ-015 Player-2 keys SHALL be 0x52 up, 0x51 down, 0x50 left, 0x4F right, Enter 0x28 fire.
REQ-016 Any other keycode SHALL produce no command and SHALL leave dir unchanged.
REQ-017 When frame_tick=1 and key_q is a player's direction key, the next edge SHALL set that player's dir to the decoded value and pulse move for exactly one cycle.
REQ-018 Holding a direction key SHALL produce one move pulse per frame_tick; there SHALL be no move between ticks.
REQ-019 A fire edge SHALL be key_q equal to the player's fire key and key_prev not equal to it.
REQ-020 The fire edge SHALL give a fire pulse at the next edge, i.e. high in the cycle after the second Clk edge following the keycode change, only if that player is in READY.
REQ-021 Fire FSM per player, READY -> COOLDOWN on a fire pulse: load cooldown counter with FIRE_COOLDOWN.
REQ-022 Fire FSM per player, COOLDOWN: counter decrements on each frame_tick; on reaching 0, go to READY on the same edge.
REQ-023 A fire edge during COOLDOWN SHALL be discarded and not queued.
REQ-024 When a fire edge and frame_tick coincide in READY, the load SHALL win and the counter SHALL equal FIRE_COOLDOWN.
REQ-025 When frame_tick arrives in COOLDOWN with count 1 and a fire edge occurs in the same cycle, SHALL go to READY without firing.
REQ-026 While freeze=1, all move and fire outputs SHALL be 0, dir SHALL hold, and cooldown counters SHALL continue to count.
REQ-027 Edges occurring during freeze SHALL be lost.
REQ-028 Only one keycode is present at a time, so both players SHALL never receive commands in the same cycle.

Reset
REQ-029 Reset_n low SHALL asynchronously clear key_q and key_prev to 0x00, move and fire to 0, counters to 0, and both FSMs to READY (ready=1).
REQ-030 Reset_n low SHALL set p1_dir=P1_INIT_DIR and p2_dir=P2_INIT_DIR.
REQ-031 Reset mid-cooldown SHALL abort the cooldown.
REQ-032 A fire key held through reset release SHALL NOT fire, because key_prev and key_q go to the fire code on consecutive edges; the first key_q!=key_prev transition after release does fire.

Configuration
REQ-033 Macro KEYCMD_AUTOFIRE_EN defined: while the fire key stays held (key_q==fire key), entering READY from COOLDOWN SHALL itself generate a fire pulse and reload the counter, giving one shot every FIRE_COOLDOWN frames.
REQ-034 Macro KEYCMD_AUTOFIRE_EN undefined: only key edges fire; a held key fires once.

Structure
REQ-035 Package keycmd_pkg SHALL hold the dir_t enum (UP, DOWN, LEFT, RIGHT), the fire_state_t enum (READY, COOLDOWN), and the ten keycode localparams.
REQ-036 Sub-module keycmd_player SHALL contain the decode, dir register, move/fire generation and fire FSM; it SHALL be instantiated twice with player key constants as parameters.
REQ-037 Top level SHALL hold only the shared key_q/key_prev registers.

Verification
REQ-038 Reset, then keycode=0x1A with 3 frame_ticks -> 3 p1_move pulses each one cycle after a tick, p1_dir=0; p2 silent.
REQ-039 keycode 0x00->0x2C -> p1_fire high for one cycle, 2 edges after the change; p1_ready=0; second press within 30 ticks -> no fire; after 30 ticks ready=1 and a press fires.
REQ-040 FIRE_COOLDOWN=1, fire edge coincident with frame_tick -> counter=1, READY after the next tick.
REQ-041 freeze=1 with keycode 0x4F and ticks -> no p2_move, p2_dir stays 1; release freeze -> moves resume.
REQ-042 KEYCMD_AUTOFIRE_EN, Enter held 100 ticks, cooldown 30 -> fires at t0, +30, +60, +90 (4 pulses); undefined -> 1 pulse.
REQ-043 Reset_n pulsed mid-cooldown while Space held -> ready=1, no fire until a new press.
